// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
//
// Main-memory side of the cache-controller memory handshake. It owns the
// backing word array. It serves two request types:
//   - block refills (main_read): returns BLOCK_WORDS words of the aligned block
//   - single-word write-throughs (main_write)
// Each request completes after a fixed access latency, marked by a
// one-cycle ready pulse.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset       : asynchronous, active-low reset
//   main_read   : block read request, held by the requester until ready
//   main_write  : word write request, held by the requester until ready
//   address     : word address of the request
//   data_in     : write data
//   data_out    : last refill block, word k at [k*DATA_W +: DATA_W]
//   ready       : registered one-cycle completion pulse
//   busy        : high while a request is waiting or completing
// ---------------------------------------------------------------------------
module main_memory_responder #(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int BLOCK_WORDS   = 4,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          main_read,
   input  logic                          main_write,
   input  logic [ADDR_W-1:0]             address,
   input  logic [DATA_W-1:0]             data_in,
   output logic [BLOCK_WORDS*DATA_W-1:0] data_out,
   output logic                          ready,
   output logic                          busy
);

   localparam int OFF     = $clog2(BLOCK_WORDS);
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int DEPTH   = 2 ** ADDR_W;

   localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      DONE
   } state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               count_q, count_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [DATA_W-1:0]              wdata_q, wdata_d;
   logic [BLOCK_WORDS*DATA_W-1:0]  refill_q, refill_d;
   logic                           ready_q, ready_d;
   logic                           busy_q, busy_d;
   logic                           mem_we;
   logic [BLOCK_WORDS*DATA_W-1:0]  block_rd;

   // Backing array; deliberately not reset so its contents survive reset.
   logic [DATA_W-1:0]              mem_q [0:DEPTH-1];

   // Gather the aligned block around the latched address. Offset bits are
   // replaced rather than added, so a block never spills into its neighbour.
   always_comb begin
      block_rd = '0;
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         block_rd[k*DATA_W +: DATA_W] = mem_q[{addr_q[ADDR_W-1:OFF], OFF'(k)}];
      end
   end

   // Next-state logic. Requests are only looked at in IDLE; once accepted,
   // the latched address/data drive the access, so dropping or changing the
   // request inputs mid-wait has no effect. Write takes priority over read.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      refill_d = refill_q;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      mem_we   = 1'b0;

      case (state_q)
         IDLE: begin
            if (main_write) begin
               state_d = WRITE_WAIT;
               addr_d  = address;
               wdata_d = data_in;
               count_d = WRITE_LOAD;
               busy_d  = 1'b1;
            end else if (main_read) begin
               state_d = READ_WAIT;
               addr_d  = address;
               wdata_d = data_in;
               count_d = READ_LOAD;
               busy_d  = 1'b1;
            end
         end

         READ_WAIT: begin
            busy_d = 1'b1;
            if (count_q == '0) begin
               refill_d = block_rd;
               state_d  = DONE;
               ready_d  = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end

         WRITE_WAIT: begin
            busy_d = 1'b1;
            if (count_q == '0) begin
               mem_we  = 1'b1;
               state_d = DONE;
               ready_d = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers. ready/busy are registered so there is
   // no combinational path from the request inputs to the handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         refill_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         refill_q <= refill_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // Array write port. An asynchronous reset forces state_q to IDLE, so an
   // access that reset interrupts never reaches the array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign data_out = refill_q;
   assign ready    = ready_q;
   assign busy     = busy_q;

endmodule
